// File: rtl/lcrc_pkg.sv
// Shared LCRC-32 constants and checker state encoding for the link-layer receive path.
package lcrc_pkg;

  localparam logic [31:0] LCRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] LCRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] LCRC_XOROUT    = 32'hFFFFFFFF;
  localparam int          TRAILER_BYTES  = 4;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM
  } state_t;

endpackage

// File: rtl/lcrc32_byte_step.sv
// One byte of reflected CRC-32 (LSB first); shared with the transmit-side generator.
module lcrc32_byte_step
  import lcrc_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  logic [31:0] c;

  // NOTE: blocking assignments here are intentional; each loop pass feeds the next within one evaluation.
  always_comb begin
    c = crc_in ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ LCRC_POLY_REFL) : (c >> 1);
    end
    crc_next = c;
  end

endmodule

// File: rtl/lcrc_32_check.sv
// Receive-side LCRC checker: strips the 4-byte trailer, forwards payload with fixed
// latency and reports a per-frame verdict plus saturating good/bad frame counters.
module lcrc_32_check
  import lcrc_pkg::*;
#(
  parameter int COUNT_W     = 16,
  parameter int MIN_PAYLOAD = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               in_sop,
  input  logic               in_eop,
  input  logic [7:0]         in_data,
  output logic               out_valid,
  output logic               out_sop,
  output logic               out_eop,
  output logic [7:0]         out_data,
  output logic               out_abort,
  output logic               status_valid,
  output logic               crc_ok,
  output logic               len_err,
  output logic [COUNT_W-1:0] good_cnt,
  output logic [COUNT_W-1:0] bad_cnt
);

  localparam int              PAY_W   = $clog2(MIN_PAYLOAD + 1) + 1;
  localparam logic [PAY_W-1:0] PAY_MIN = PAY_W'(MIN_PAYLOAD);

  state_t             state, state_nxt;
  logic [2:0]         fill;
  logic [7:0]         dly [TRAILER_BYTES];
  logic [31:0]        crc, crc_step;
  logic [PAY_W-1:0]   pay_cnt;
  logic               emitted;
  logic               load, shift, evict, verdict, frame_err, short_frame, match;

  lcrc32_byte_step u_step (
    .crc_in   (crc),
    .data     (dly[0]),
    .crc_next (crc_step)
  );

  // The trailer sits in the delay line after the eop shift; t0 is the oldest of the four.
  assign match       = (crc_step ^ LCRC_XOROUT) == {in_data, dly[3], dly[2], dly[1]};
  assign short_frame = (pay_cnt + PAY_W'(1)) < PAY_MIN;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    evict     = 1'b0;
    verdict   = 1'b0;
    frame_err = 1'b0;
    if (in_valid) begin
      if (in_sop) begin
        load      = 1'b1;
        verdict   = (state != IDLE) || in_eop;
        frame_err = verdict;
        state_nxt = in_eop ? IDLE : FILL;
      end else begin
        case (state)
          FILL: begin
            shift = 1'b1;
            if (in_eop) begin
              verdict   = 1'b1;
              frame_err = 1'b1;
              state_nxt = IDLE;
            end else if (fill == 3'd3) begin
              state_nxt = STREAM;
            end
          end
          STREAM: begin
            shift = 1'b1;
            evict = 1'b1;
            if (in_eop) begin
              verdict   = 1'b1;
              frame_err = short_frame;
              state_nxt = IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: the delay line carries no reset; fill gating guarantees it is refilled before use.
  always_ff @(posedge clk) begin
    if (load || shift) begin
      for (int i = 0; i < TRAILER_BYTES - 1; i++) dly[i] <= dly[i+1];
      dly[TRAILER_BYTES-1] <= in_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      fill         <= '0;
      crc          <= LCRC_INIT;
      pay_cnt      <= '0;
      emitted      <= 1'b0;
      out_valid    <= 1'b0;
      out_sop      <= 1'b0;
      out_eop      <= 1'b0;
      out_data     <= '0;
      out_abort    <= 1'b0;
      status_valid <= 1'b0;
      crc_ok       <= 1'b0;
      len_err      <= 1'b0;
      good_cnt     <= '0;
      bad_cnt      <= '0;
    end else begin
      state        <= state_nxt;
      out_valid    <= evict;
      out_sop      <= evict && !emitted;
      out_eop      <= evict && verdict && !frame_err;
      out_data     <= evict ? dly[0] : 8'h00;
      out_abort    <= verdict && frame_err && (evict || emitted);
      status_valid <= verdict;
      crc_ok       <= verdict && !frame_err && match;
      len_err      <= verdict && frame_err;

      if (load) begin
        fill    <= 3'd1;
        crc     <= LCRC_INIT;
        pay_cnt <= '0;
      end else begin
        if (shift && state == FILL) fill <= fill + 3'd1;
        if (evict) begin
          crc <= crc_step;
          if (pay_cnt != PAY_MIN) pay_cnt <= pay_cnt + PAY_W'(1);
        end
      end

      if (load || verdict) emitted <= 1'b0;
      else if (evict)      emitted <= 1'b1;

      if (verdict) begin
        if (!frame_err && match) begin
          if (good_cnt != '1) good_cnt <= good_cnt + COUNT_W'(1);
        end else if (bad_cnt != '1) begin
          bad_cnt <= bad_cnt + COUNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_lcrc_32_check.sv
// Directed bench for lcrc_32_check: good/corrupt/gapped/short/abort/reset/saturation scenarios.
module tb_lcrc_32_check;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        out_valid, out_sop, out_eop, out_abort, status_valid, crc_ok, len_err;
  logic [7:0]  out_data;
  logic [15:0] good_cnt, bad_cnt;
  logic        s_out_valid, s_out_sop, s_out_eop, s_out_abort, s_status_valid, s_crc_ok, s_len_err;
  logic [7:0]  s_out_data;
  logic [1:0]  s_good_cnt, s_bad_cnt;

  int passed = 0, total = 0;
  int cyc = 0, first_cyc, eop_cyc, stat_cyc, abort_n, abort_at;
  logic [7:0] cap_data[$];
  bit cap_sop[$], cap_eop[$], stat_ok[$], stat_len[$];

  lcrc_32_check dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_data(in_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_data(out_data), .out_abort(out_abort), .status_valid(status_valid),
    .crc_ok(crc_ok), .len_err(len_err), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
  );

  lcrc_32_check #(.COUNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_data(in_data), .out_valid(s_out_valid), .out_sop(s_out_sop), .out_eop(s_out_eop),
    .out_data(s_out_data), .out_abort(s_out_abort), .status_valid(s_status_valid),
    .crc_ok(s_crc_ok), .len_err(s_len_err), .good_cnt(s_good_cnt), .bad_cnt(s_bad_cnt)
  );

  always #5 clk = ~clk;

  byte_q_t good_f    = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                         8'h26, 8'h39, 8'hF4, 8'hCB};
  byte_q_t corrupt_f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                         8'h26, 8'h39, 8'hF4, 8'hCA};
  byte_q_t one_f     = '{8'h61, 8'h43, 8'hBE, 8'hB7, 8'hE8};
  byte_q_t short_f   = '{8'h11, 8'h22, 8'h33, 8'h44};

  localparam logic [127:0] GOOD_PAY = 128'h313233343536373839;

  task automatic clear_cap();
    cap_data.delete(); cap_sop.delete(); cap_eop.delete();
    stat_ok.delete(); stat_len.delete();
    first_cyc = -1; eop_cyc = -1; stat_cyc = -2; abort_n = 0; abort_at = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (out_valid) begin
      if (first_cyc < 0) first_cyc = cyc;
      cap_data.push_back(out_data);
      cap_sop.push_back(out_sop);
      cap_eop.push_back(out_eop);
      if (out_eop) eop_cyc = cyc;
    end
    if (out_abort) begin
      abort_n++;
      abort_at = cap_data.size();
    end
    if (status_valid) begin
      stat_ok.push_back(crc_ok);
      stat_len.push_back(len_err);
      stat_cyc = cyc;
    end
  endtask

  task automatic put(input bit s, input bit e, input logic [7:0] d);
    in_valid = 1'b1; in_sop = s; in_eop = e; in_data = d;
    tick();
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_frame(input byte_q_t f, input int gap);
    foreach (f[i]) begin
      put(i == 0, i == f.size() - 1, f[i]);
      if (i != f.size() - 1) idle(gap);
    end
    idle(2);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    clear_cap();
  endtask

  function automatic logic [127:0] cap_bytes();
    logic [127:0] r = '0;
    foreach (cap_data[i]) r = {r[119:0], cap_data[i]};
    return r;
  endfunction

  function automatic logic [15:0] sop_vec();
    logic [15:0] r = '0;
    foreach (cap_sop[i]) r = {r[14:0], cap_sop[i]};
    return r;
  endfunction

  function automatic logic [15:0] eop_vec();
    logic [15:0] r = '0;
    foreach (cap_eop[i]) r = {r[14:0], cap_eop[i]};
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick();
    total++;
    if ({out_valid, out_sop, out_eop, out_abort, status_valid, crc_ok, len_err, out_data} !== 15'd0)
      $display("FAIL reset_outputs: got %h expected 0",
               {out_valid, out_sop, out_eop, out_abort, status_valid, crc_ok, len_err, out_data});
    else passed++;
    total++;
    if ({good_cnt, bad_cnt} !== 32'd0) $display("FAIL reset_counters: got %h expected 0", {good_cnt, bad_cnt});
    else passed++;
    reset = 1'b0;
    clear_cap();
    put(1'b0, 1'b0, 8'h55);
    put(1'b0, 1'b1, 8'h66);
    idle(6);
    total++;
    if (cap_data.size() + stat_ok.size() !== 0)
      $display("FAIL idle_ignore: got %0d events expected 0", cap_data.size() + stat_ok.size());
    else passed++;
  endtask

  task automatic test_good_frame();
    int c0;
    do_reset();
    c0 = cyc;
    send_frame(good_f, 0);
    total++;
    if (cap_bytes() !== GOOD_PAY) $display("FAIL good_payload: got %h expected %h", cap_bytes(), GOOD_PAY);
    else passed++;
    total++;
    if ({sop_vec(), eop_vec()} !== {16'h0100, 16'h0001})
      $display("FAIL good_sop_eop: got %h expected %h", {sop_vec(), eop_vec()}, {16'h0100, 16'h0001});
    else passed++;
    total++;
    if (first_cyc !== c0 + 5) $display("FAIL good_latency: got %0d expected %0d", first_cyc, c0 + 5);
    else passed++;
    total++;
    if (stat_ok.size() !== 1 || stat_cyc !== eop_cyc)
      $display("FAIL good_status_pulse: got %0d pulses at %0d expected 1 at %0d", stat_ok.size(), stat_cyc, eop_cyc);
    else passed++;
    total++;
    if ({stat_ok[0], stat_len[0]} !== 2'b10) $display("FAIL good_verdict: got %b expected 10", {stat_ok[0], stat_len[0]});
    else passed++;
    total++;
    if ({good_cnt, bad_cnt} !== {16'd1, 16'd0}) $display("FAIL good_counters: got %h expected %h", {good_cnt, bad_cnt}, {16'd1, 16'd0});
    else passed++;
  endtask

  task automatic test_corrupt_trailer();
    do_reset();
    send_frame(corrupt_f, 0);
    total++;
    if (cap_bytes() !== GOOD_PAY) $display("FAIL corrupt_payload: got %h expected %h", cap_bytes(), GOOD_PAY);
    else passed++;
    total++;
    if (stat_ok.size() !== 1 || {stat_ok[0], stat_len[0]} !== 2'b00)
      $display("FAIL corrupt_verdict: got %0d pulses ok/len %b expected 1 pulse 00", stat_ok.size(), {stat_ok[0], stat_len[0]});
    else passed++;
    total++;
    if ({good_cnt, bad_cnt} !== {16'd0, 16'd1}) $display("FAIL corrupt_counters: got %h expected %h", {good_cnt, bad_cnt}, {16'd0, 16'd1});
    else passed++;
  endtask

  task automatic test_gapped();
    do_reset();
    send_frame(good_f, 3);
    total++;
    if (cap_bytes() !== GOOD_PAY || {sop_vec(), eop_vec()} !== {16'h0100, 16'h0001})
      $display("FAIL gapped_payload: got %h flags %h expected %h flags %h", cap_bytes(), {sop_vec(), eop_vec()}, GOOD_PAY, {16'h0100, 16'h0001});
    else passed++;
    total++;
    if (stat_ok.size() !== 1 || stat_ok[0] !== 1'b1 || good_cnt !== 16'd1)
      $display("FAIL gapped_verdict: got %0d pulses ok %b good %0d expected 1 pulse ok 1 good 1", stat_ok.size(), stat_ok[0], good_cnt);
    else passed++;
  endtask

  task automatic test_min_payload();
    do_reset();
    send_frame(one_f, 0);
    total++;
    if (cap_bytes() !== 128'h61 || {sop_vec(), eop_vec()} !== {16'h0001, 16'h0001})
      $display("FAIL min_payload: got %h flags %h expected 61 flags %h", cap_bytes(), {sop_vec(), eop_vec()}, {16'h0001, 16'h0001});
    else passed++;
    total++;
    if (stat_ok.size() !== 1 || {stat_ok[0], stat_len[0]} !== 2'b10 || good_cnt !== 16'd1)
      $display("FAIL min_verdict: got %0d pulses ok/len %b good %0d expected 1 pulse 10 good 1", stat_ok.size(), {stat_ok[0], stat_len[0]}, good_cnt);
    else passed++;
  endtask

  task automatic test_short_frame();
    do_reset();
    send_frame(short_f, 0);
    total++;
    if (cap_data.size() !== 0 || abort_n !== 0)
      $display("FAIL short_no_output: got %0d bytes %0d aborts expected 0 0", cap_data.size(), abort_n);
    else passed++;
    total++;
    if (stat_ok.size() !== 1 || {stat_ok[0], stat_len[0]} !== 2'b01)
      $display("FAIL short_verdict: got %0d pulses ok/len %b expected 1 pulse 01", stat_ok.size(), {stat_ok[0], stat_len[0]});
    else passed++;
    total++;
    if ({good_cnt, bad_cnt} !== {16'd0, 16'd1}) $display("FAIL short_counters: got %h expected %h", {good_cnt, bad_cnt}, {16'd0, 16'd1});
    else passed++;
  endtask

  task automatic test_abort_recover();
    do_reset();
    put(1'b1, 1'b0, 8'h31);
    for (int i = 1; i < 6; i++) put(1'b0, 1'b0, 8'h31 + 8'(i));
    send_frame(good_f, 0);
    total++;
    if (abort_n !== 1 || abort_at !== 2)
      $display("FAIL abort_pulse: got %0d pulses after %0d bytes expected 1 after 2", abort_n, abort_at);
    else passed++;
    total++;
    if (cap_bytes() !== 128'h3132313233343536373839 || {sop_vec(), eop_vec()} !== {16'h0500, 16'h0001})
      $display("FAIL abort_payload: got %h flags %h expected %h flags %h", cap_bytes(), {sop_vec(), eop_vec()}, 128'h3132313233343536373839, {16'h0500, 16'h0001});
    else passed++;
    total++;
    if (stat_ok.size() !== 2 || {stat_ok[0], stat_len[0], stat_ok[1], stat_len[1]} !== 4'b0110)
      $display("FAIL abort_verdicts: got %0d pulses %b expected 2 pulses 0110", stat_ok.size(), {stat_ok[0], stat_len[0], stat_ok[1], stat_len[1]});
    else passed++;
    total++;
    if ({good_cnt, bad_cnt} !== {16'd1, 16'd1}) $display("FAIL abort_counters: got %h expected %h", {good_cnt, bad_cnt}, {16'd1, 16'd1});
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    send_frame(good_f, 0);
    put(1'b1, 1'b0, 8'h31);
    for (int i = 1; i < 6; i++) put(1'b0, 1'b0, 8'h31 + 8'(i));
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h32) $display("FAIL mid_streaming: got v%b %h expected v1 32", out_valid, out_data);
    else passed++;
    clear_cap();
    reset = 1'b1;
    put(1'b0, 1'b0, 8'h37);
    reset = 1'b0;
    total++;
    if ({out_valid, out_sop, out_eop, out_abort, status_valid, out_data} !== 13'd0 || {good_cnt, bad_cnt} !== 32'd0)
      $display("FAIL mid_reset_state: got %h cnt %h expected 0 cnt 0", {out_valid, out_sop, out_eop, out_abort, status_valid, out_data}, {good_cnt, bad_cnt});
    else passed++;
    put(1'b0, 1'b0, 8'h38);
    put(1'b0, 1'b1, 8'h39);
    idle(6);
    total++;
    if (stat_ok.size() !== 0 || cap_data.size() !== 0)
      $display("FAIL mid_reset_silent: got %0d pulses %0d bytes expected 0 0", stat_ok.size(), cap_data.size());
    else passed++;
  endtask

  task automatic test_saturation();
    do_reset();
    repeat (5) begin
      put(1'b1, 1'b1, 8'hAA);
      idle(1);
    end
    idle(2);
    total++;
    if (stat_ok.size() !== 5 || stat_len[4] !== 1'b1) $display("FAIL sat_pulses: got %0d len %b expected 5 len 1", stat_ok.size(), stat_len[4]);
    else passed++;
    total++;
    if ({s_good_cnt, s_bad_cnt} !== 4'b0011) $display("FAIL sat_counter: got %b expected 0011", {s_good_cnt, s_bad_cnt});
    else passed++;
    total++;
    if (bad_cnt !== 16'd5) $display("FAIL sat_wide_counter: got %0d expected 5", bad_cnt);
    else passed++;
  endtask

  initial begin
    clear_cap();
    test_reset();
    test_good_frame();
    test_corrupt_trailer();
    test_gapped();
    test_min_payload();
    test_short_frame();
    test_abort_recover();
    test_reset_mid_frame();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
